mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data and address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, number of WAIT cycles before a timeout abort.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ex_valid  in  1  execute-stage result valid.
REQ-006 SHALL have port ex_alu_out  in  DATA_W  ALU result; also the memory address.
REQ-007 SHALL have port ex_st_data  in  DATA_W  store data.
REQ-008 SHALL have port ex_mem_rd  in  1  load operation.
REQ-009 SHALL have port ex_mem_wr  in  1  store operation.
REQ-010 SHALL have port ex_dst  in  4  destination register index.
REQ-011 SHALL have port ex_reg_wr  in  1  operation writes the register file.
REQ-012 SHALL have port stall  out  1  stage busy; upstream holds its inputs.
REQ-013 SHALL have port mem_req  out  1  memory request, held until ack.
REQ-014 SHALL have port mem_we  out  1  1 = write, 0 = read.
REQ-015 SHALL have port mem_addr  out  DATA_W  memory address.
REQ-016 SHALL have port mem_wdata  out  DATA_W  memory write data.
REQ-017 SHALL have port mem_rdata  in  DATA_W  memory read data, valid while mem_ack=1.
REQ-018 SHALL have port mem_ack  in  1  one-cycle completion pulse from memory.
REQ-019 SHALL have port wb_valid  out  1  writeback bundle valid, one-cycle pulse.
REQ-020 SHALL have ports wb_data  out  DATA_W, wb_dst  out  4, wb_reg_wr  out  1, forming the writeback bundle.
REQ-021 SHALL have port mem_err  out  1  timeout abort flag, pulsed together with wb_valid.

Function
REQ-022 SHALL implement a two-state FSM, IDLE and WAIT; stall SHALL equal (state==WAIT) combinationally, including the ack cycle.
REQ-023 SHALL define accept as ex_valid && !stall; ex_mem_rd and ex_mem_wr both high SHALL be treated as a store.
REQ-024 On accept of a non-memory op: wb_valid=1, wb_data=ex_alu_out, wb_dst=ex_dst, wb_reg_wr=ex_reg_wr, all on the next edge (latency 1); state stays IDLE.
REQ-025 On accept of a load or store: the address, data, dst and reg_wr fields SHALL be latched, and the FSM SHALL go to WAIT; mem_req, mem_we, mem_addr and mem_wdata SHALL be registered outputs, valid from the first WAIT cycle.
REQ-026 In WAIT, mem_req and all mem_* outputs SHALL stay constant until the cycle mem_ack=1, and mem_req SHALL drop on the following edge.
REQ-027 On the mem_ack edge, a load SHALL produce wb_valid=1, wb_data=mem_rdata, wb_reg_wr=latched reg_wr.
REQ-028 On the mem_ack edge, a store SHALL produce wb_valid=1, wb_data=stored address, wb_reg_wr=0.
REQ-029 After the mem_ack edge the FSM SHALL return to IDLE, giving a minimum memory-op latency of 2 cycles from accept to wb_valid.
REQ-030 mem_ack received in IDLE SHALL be ignored, and wb_valid SHALL be 0 in every cycle without a completion.

Reset
REQ-031 On rst_n low, state=IDLE, and mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_dst, wb_reg_wr and mem_err SHALL all be 0 immediately, without waiting for a clock edge.
REQ-032 Reset during WAIT SHALL abandon the request with no writeback, and a later stale mem_ack SHALL be ignored.

Configuration
REQ-033 With MEM_STAGE_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; after TIMEOUT cycles without ack, the block SHALL return to IDLE and pulse wb_valid=1, wb_reg_wr=0, mem_err=1 on the same edge.
REQ-034 Without MEM_STAGE_TIMEOUT_EN, WAIT SHALL last indefinitely, no counter logic SHALL exist, and mem_err SHALL be tied to 0.

Structure
REQ-035 Package cpu_pkg SHALL hold the mem_state_t enum (IDLE, WAIT), DATA_W_DEF=16, REG_IDX_W=4 and TIMEOUT_DEF=16.
REQ-036 The timeout counter SHALL be the sub-module mem_timeout_ctr, with ports clk, rst_n, clear, run and expired, instantiated only under MEM_STAGE_TIMEOUT_EN.

Verification
REQ-037 Bench SHALL cover: non-memory op with alu_out=0x1234, dst=3, reg_wr=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_dst=3, stall never high.
REQ-038 Bench SHALL cover: load from address 0x0040 with ack 3 cycles into WAIT and rdata=0xBEEF -> stall high for 3 cycles; wb_valid=1 with wb_data=0xBEEF one edge after ack; mem_req low after that edge.
REQ-039 Bench SHALL cover: store of 0x55AA to address 0x0010 with ack in the first WAIT cycle -> mem_we=1, mem_wdata=0x55AA; wb_valid=1 with wb_reg_wr=0 two cycles after accept.
REQ-040 Bench SHALL cover: load held off by stall with ex_valid held high -> the load is accepted exactly once, on the cycle after the prior op's ack edge.
REQ-041 Bench SHALL cover: rst_n low in the 2nd WAIT cycle, then ack one cycle after reset release -> mem_req drops immediately, no wb_valid is produced, and the ack is ignored.
REQ-042 Bench SHALL cover, with MEM_STAGE_TIMEOUT_EN defined: no ack for 16 cycles -> wb_valid=1 and mem_err=1 on the same edge, the FSM returns to IDLE, and stall is low on the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU memory stage.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned REG_IDX_W   = 4;
  localparam int unsigned TIMEOUT_DEF = 16;

  // Memory-stage FSM: IDLE accepts new ops, WAIT holds a request until ack.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// WAIT-cycle counter for the memory stage timeout abort.
// Counts cycles while run is high; expired flags the TIMEOUT-th cycle.
module mem_timeout_ctr
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned     CntW    = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_cnt;

  // r_cnt holds the number of run cycles already completed, so the k-th run cycle sees k-1.
  assign expired = run && (r_cnt == LastCnt);

  // Count run cycles; saturate at the expiry value, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run && !expired) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// CPU memory stage: passes ALU results straight to writeback and runs
// loads/stores through a req/ack memory handshake, stalling upstream while busy.
// Optional feature: define MEM_STAGE_TIMEOUT_EN to abort a request after
// TIMEOUT WAIT cycles without ack (writeback pulse with mem_err=1).
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic [DATA_W-1:0]    ex_alu_out,
  input  logic [DATA_W-1:0]    ex_st_data,
  input  logic                 ex_mem_rd,
  input  logic                 ex_mem_wr,
  input  logic [REG_IDX_W-1:0] ex_dst,
  input  logic                 ex_reg_wr,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic                 wb_valid,
  output logic [DATA_W-1:0]    wb_data,
  output logic [REG_IDX_W-1:0] wb_dst,
  output logic                 wb_reg_wr,
  output logic                 mem_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT must be at least 1");
  end

  mem_state_t r_state, w_state_d;

  logic                 r_mem_req,   w_mem_req_d;
  logic                 r_mem_we,    w_mem_we_d;
  logic [DATA_W-1:0]    r_mem_addr,  w_mem_addr_d;
  logic [DATA_W-1:0]    r_mem_wdata, w_mem_wdata_d;
  logic [REG_IDX_W-1:0] r_dst,       w_dst_d;
  logic                 r_reg_wr,    w_reg_wr_d;
  logic                 r_wb_valid,  w_wb_valid_d;
  logic [DATA_W-1:0]    r_wb_data,   w_wb_data_d;
  logic [REG_IDX_W-1:0] r_wb_dst,    w_wb_dst_d;
  logic                 r_wb_reg_wr, w_wb_reg_wr_d;

  logic w_accept;
  logic w_is_mem;
  logic w_done;
  logic w_timeout;

  assign stall    = (r_state == WAIT);
  assign w_accept = ex_valid && !stall;
  assign w_is_mem = ex_mem_rd || ex_mem_wr;
  // Ack only means something while a request is outstanding.
  assign w_done   = (r_state == WAIT) && mem_ack;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic w_ctr_clear;
  logic w_ctr_run;
  logic w_expired;
  logic r_mem_err;

  assign w_ctr_clear = (r_state == IDLE);
  assign w_ctr_run   = (r_state == WAIT);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_ctr_clear),
    .run     (w_ctr_run),
    .expired (w_expired)
  );

  // A late ack in the expiry cycle still completes normally.
  assign w_timeout = (r_state == WAIT) && !mem_ack && w_expired;

  // Error flag pulses on the same edge as the abort writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_timeout;
    end
  end

  assign mem_err = r_mem_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic: enter WAIT on an accepted load/store, leave on ack or timeout.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && w_is_mem) begin
          w_state_d = WAIT;
        end
      end
      WAIT: begin
        if (w_done || w_timeout) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered memory port and writeback bundle.
  always_comb begin
    w_mem_req_d   = r_mem_req;
    w_mem_we_d    = r_mem_we;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_dst_d       = r_dst;
    w_reg_wr_d    = r_reg_wr;
    w_wb_valid_d  = 1'b0;
    w_wb_data_d   = r_wb_data;
    w_wb_dst_d    = r_wb_dst;
    w_wb_reg_wr_d = r_wb_reg_wr;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_mem) begin
            // Both rd and wr high is treated as a store.
            w_mem_req_d   = 1'b1;
            w_mem_we_d    = ex_mem_wr;
            w_mem_addr_d  = ex_alu_out;
            w_mem_wdata_d = ex_st_data;
            w_dst_d       = ex_dst;
            w_reg_wr_d    = ex_reg_wr;
          end else begin
            w_wb_valid_d  = 1'b1;
            w_wb_data_d   = ex_alu_out;
            w_wb_dst_d    = ex_dst;
            w_wb_reg_wr_d = ex_reg_wr;
          end
        end
      end
      WAIT: begin
        if (w_done) begin
          w_mem_req_d  = 1'b0;
          w_wb_valid_d = 1'b1;
          w_wb_dst_d   = r_dst;
          if (r_mem_we) begin
            // Stores report their address and never write the register file.
            w_wb_data_d   = r_mem_addr;
            w_wb_reg_wr_d = 1'b0;
          end else begin
            w_wb_data_d   = mem_rdata;
            w_wb_reg_wr_d = r_reg_wr;
          end
        end else if (w_timeout) begin
          w_mem_req_d   = 1'b0;
          w_wb_valid_d  = 1'b1;
          w_wb_dst_d    = r_dst;
          w_wb_data_d   = r_mem_addr;
          w_wb_reg_wr_d = 1'b0;
        end
      end
      default: begin
        w_mem_req_d = 1'b0;
      end
    endcase
  end

  // Registered memory port, latched op fields and writeback bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dst       <= '0;
      r_reg_wr    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_dst    <= '0;
      r_wb_reg_wr <= 1'b0;
    end else begin
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_dst       <= w_dst_d;
      r_reg_wr    <= w_reg_wr_d;
      r_wb_valid  <= w_wb_valid_d;
      r_wb_data   <= w_wb_data_d;
      r_wb_dst    <= w_wb_dst_d;
      r_wb_reg_wr <= w_wb_reg_wr_d;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_data   = r_wb_data;
  assign wb_dst    = r_wb_dst;
  assign wb_reg_wr = r_wb_reg_wr;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table-driven ALU ops, directed multi-cycle sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid;
  logic [DW-1:0] ex_alu_out;
  logic [DW-1:0] ex_st_data;
  logic          ex_mem_rd;
  logic          ex_mem_wr;
  logic [3:0]    ex_dst;
  logic          ex_reg_wr;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [3:0]    wb_dst;
  logic          wb_reg_wr;
  logic          mem_err;

  mem_stage #(
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_alu_out (ex_alu_out),
    .ex_st_data (ex_st_data),
    .ex_mem_rd  (ex_mem_rd),
    .ex_mem_wr  (ex_mem_wr),
    .ex_dst     (ex_dst),
    .ex_reg_wr  (ex_reg_wr),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_dst     (wb_dst),
    .wb_reg_wr  (wb_reg_wr),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid   = 1'b0;
    ex_mem_rd  = 1'b0;
    ex_mem_wr  = 1'b0;
    ex_reg_wr  = 1'b0;
    ex_dst     = '0;
    ex_alu_out = '0;
    ex_st_data = '0;
  endtask

  // ALU-op vectors: one accept per row, result expected after one edge.
  typedef struct {
    logic          v;
    logic [DW-1:0] alu;
    logic [3:0]    dst;
    logic          reg_wr;
    logic          ack;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [3:0]    e_dst;
    logic          e_reg_wr;
  } alu_vec_t;

  alu_vec_t vecs[6];

  // Reference model state: one outstanding memory transaction at most.
  bit            m_busy;
  int            m_waited;
  bit            m_is_st;
  logic [DW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_dst;
  logic          m_reg_wr;
  bit            e_wb_valid;
  bit            e_err;
  logic [DW-1:0] e_wb_data;
  logic [3:0]    e_wb_dst;
  logic          e_wb_reg_wr;

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_edge();
    e_wb_valid = 1'b0;
    e_err      = 1'b0;
    if (!m_busy) begin
      if (ex_valid) begin
        if (ex_mem_rd || ex_mem_wr) begin
          m_busy   = 1'b1;
          m_waited = 0;
          m_is_st  = ex_mem_wr;
          m_addr   = ex_alu_out;
          m_wdata  = ex_st_data;
          m_dst    = ex_dst;
          m_reg_wr = ex_reg_wr;
        end else begin
          e_wb_valid  = 1'b1;
          e_wb_data   = ex_alu_out;
          e_wb_dst    = ex_dst;
          e_wb_reg_wr = ex_reg_wr;
        end
      end
    end else begin
      m_waited++;
      if (mem_ack) begin
        e_wb_valid  = 1'b1;
        e_wb_dst    = m_dst;
        e_wb_data   = m_is_st ? m_addr : mem_rdata;
        e_wb_reg_wr = m_is_st ? 1'b0 : m_reg_wr;
        m_busy      = 1'b0;
      end else if (ToEn && m_waited == int'(TO)) begin
        e_wb_valid  = 1'b1;
        e_err       = 1'b1;
        e_wb_reg_wr = 1'b0;
        m_busy      = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cycles;
    int extra_wb;
    int sel;

    vecs[0] = '{1'b1, 16'h1234, 4'd3,  1'b1, 1'b0, 1'b1, 16'h1234, 4'd3,  1'b1};
    vecs[1] = '{1'b1, 16'hFFFF, 4'd15, 1'b0, 1'b0, 1'b1, 16'hFFFF, 4'd15, 1'b0};
    vecs[2] = '{1'b0, 16'hAAAA, 4'd1,  1'b1, 1'b1, 1'b0, 16'h0000, 4'd0,  1'b0};
    vecs[3] = '{1'b1, 16'h0000, 4'd0,  1'b1, 1'b0, 1'b1, 16'h0000, 4'd0,  1'b1};
    vecs[4] = '{1'b1, 16'h8001, 4'd9,  1'b1, 1'b1, 1'b1, 16'h8001, 4'd9,  1'b1};
    vecs[5] = '{1'b0, 16'h5A5A, 4'd6,  1'b0, 1'b0, 1'b0, 16'h0000, 4'd0,  1'b0};

    ex_idle();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    // Reset values must appear before any clock edge.
    chk("rst_stall",     32'(stall),     32'h0);
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_mem_we",    32'(mem_we),    32'h0);
    chk("rst_mem_addr",  32'(mem_addr),  32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_wb_valid",  32'(wb_valid),  32'h0);
    chk("rst_wb_data",   32'(wb_data),   32'h0);
    chk("rst_wb_dst",    32'(wb_dst),    32'h0);
    chk("rst_wb_reg_wr", 32'(wb_reg_wr), 32'h0);
    chk("rst_mem_err",   32'(mem_err),   32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ALU ops (table), including an IDLE ack that must be ignored.
    for (int i = 0; i < 6; i++) begin
      ex_valid   = vecs[i].v;
      ex_alu_out = vecs[i].alu;
      ex_dst     = vecs[i].dst;
      ex_reg_wr  = vecs[i].reg_wr;
      ex_mem_rd  = 1'b0;
      ex_mem_wr  = 1'b0;
      mem_ack    = vecs[i].ack;
      mem_rdata  = 16'hDEAD;
      chk("alu_stall_pre", 32'(stall), 32'h0);
      tick();
      chk("alu_stall", 32'(stall), 32'h0);
      chk("alu_mem_req", 32'(mem_req), 32'h0);
      chk("alu_wb_valid", 32'(wb_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk("alu_wb_data",   32'(wb_data),   32'(vecs[i].e_data));
        chk("alu_wb_dst",    32'(wb_dst),    32'(vecs[i].e_dst));
        chk("alu_wb_reg_wr", 32'(wb_reg_wr), 32'(vecs[i].e_reg_wr));
      end
    end
    ex_idle();
    mem_ack = 1'b0;
    tick();

    // Load from 0x0040, ack in the 3rd WAIT cycle.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_out = 16'h0040; ex_dst = 4'd5; ex_reg_wr = 1'b1;
    tick();
    ex_idle();
    chk("ld_mem_req", 32'(mem_req), 32'h1);
    chk("ld_mem_we", 32'(mem_we), 32'h0);
    chk("ld_mem_addr", 32'(mem_addr), 32'h0040);
    stall_cycles = 0;
    for (int c = 1; c <= 3; c++) begin
      if (stall) stall_cycles++;
      chk("ld_wait_wb_valid", 32'(wb_valid), 32'h0);
      chk("ld_wait_addr_hold", 32'(mem_addr), 32'h0040);
      if (c == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
      end
      tick();
    end
    mem_ack = 1'b0;
    chk("ld_stall_cycles", 32'(stall_cycles), 32'd3);
    chk("ld_wb_valid", 32'(wb_valid), 32'h1);
    chk("ld_wb_data", 32'(wb_data), 32'hBEEF);
    chk("ld_wb_dst", 32'(wb_dst), 32'h5);
    chk("ld_wb_reg_wr", 32'(wb_reg_wr), 32'h1);
    chk("ld_req_dropped", 32'(mem_req), 32'h0);
    chk("ld_stall_low", 32'(stall), 32'h0);
    tick();
    chk("ld_wb_pulse_end", 32'(wb_valid), 32'h0);

    // Store 0x55AA to 0x0010, ack in the first WAIT cycle.
    ex_valid = 1'b1; ex_mem_wr = 1'b1; ex_alu_out = 16'h0010; ex_st_data = 16'h55AA;
    ex_dst = 4'd7; ex_reg_wr = 1'b1;
    tick();
    ex_idle();
    chk("st_mem_we", 32'(mem_we), 32'h1);
    chk("st_mem_wdata", 32'(mem_wdata), 32'h55AA);
    chk("st_mem_addr", 32'(mem_addr), 32'h0010);
    chk("st_wb_valid_early", 32'(wb_valid), 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h9999;
    tick();
    mem_ack = 1'b0;
    chk("st_wb_valid", 32'(wb_valid), 32'h1);
    chk("st_wb_reg_wr", 32'(wb_reg_wr), 32'h0);
    chk("st_wb_data", 32'(wb_data), 32'h0010);
    tick();

    // rd and wr both high behaves as a store.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b1; ex_alu_out = 16'h0222;
    ex_st_data = 16'h3C3C; ex_reg_wr = 1'b1;
    tick();
    ex_idle();
    chk("rdwr_mem_we", 32'(mem_we), 32'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rdwr_wb_reg_wr", 32'(wb_reg_wr), 32'h0);
    tick();

    // Load B held by stall behind load A; B must be taken once, after A's ack edge.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_out = 16'h0100; ex_dst = 4'd2; ex_reg_wr = 1'b1;
    tick();
    ex_alu_out = 16'h0200; ex_dst = 4'd4;
    tick();
    chk("hold_stall", 32'(stall), 32'h1);
    chk("hold_addr_a", 32'(mem_addr), 32'h0100);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    chk("hold_a_wb_valid", 32'(wb_valid), 32'h1);
    chk("hold_a_wb_data", 32'(wb_data), 32'h1111);
    chk("hold_a_wb_dst", 32'(wb_dst), 32'h2);
    chk("hold_req_low", 32'(mem_req), 32'h0);
    tick();
    ex_idle();
    chk("hold_b_req", 32'(mem_req), 32'h1);
    chk("hold_b_addr", 32'(mem_addr), 32'h0200);
    chk("hold_b_no_wb", 32'(wb_valid), 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h2222;
    tick();
    mem_ack = 1'b0;
    chk("hold_b_wb_data", 32'(wb_data), 32'h2222);
    chk("hold_b_wb_dst", 32'(wb_dst), 32'h4);
    extra_wb = 0;
    for (int c = 0; c < 3; c++) begin
      mem_ack = (c == 1);
      tick();
      if (wb_valid || mem_req) extra_wb++;
    end
    mem_ack = 1'b0;
    chk("hold_single_accept", 32'(extra_wb), 32'd0);

    // Reset in the 2nd WAIT cycle, then a stale ack after release.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_out = 16'h0300; ex_dst = 4'd8; ex_reg_wr = 1'b1;
    tick();
    ex_idle();
    tick();
    chk("rstw_in_wait", 32'(mem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_req_async", 32'(mem_req), 32'h0);
    chk("rstw_stall_async", 32'(stall), 32'h0);
    chk("rstw_wb_async", 32'(wb_valid), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    chk("rstw_stale_wb", 32'(wb_valid), 32'h0);
    chk("rstw_stale_req", 32'(mem_req), 32'h0);
    chk("rstw_stale_stall", 32'(stall), 32'h0);
    tick();

    // Long wait with no ack: timeout abort if enabled, otherwise stays in WAIT.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_out = 16'h0400; ex_dst = 4'd1; ex_reg_wr = 1'b1;
    tick();
    ex_idle();
`ifdef MEM_STAGE_TIMEOUT_EN
    for (int c = 1; c < int'(TO); c++) begin
      chk("to_waiting_wb", 32'(wb_valid), 32'h0);
      tick();
    end
    chk("to_last_stall", 32'(stall), 32'h1);
    chk("to_last_err", 32'(mem_err), 32'h0);
    tick();
    chk("to_wb_valid", 32'(wb_valid), 32'h1);
    chk("to_mem_err", 32'(mem_err), 32'h1);
    chk("to_wb_reg_wr", 32'(wb_reg_wr), 32'h0);
    chk("to_stall_low", 32'(stall), 32'h0);
    chk("to_req_low", 32'(mem_req), 32'h0);
    tick();
    chk("to_next_stall", 32'(stall), 32'h0);
    chk("to_err_pulse_end", 32'(mem_err), 32'h0);
    chk("to_wb_pulse_end", 32'(wb_valid), 32'h0);
`else
    for (int c = 0; c < 20; c++) begin
      tick();
    end
    chk("nto_still_stall", 32'(stall), 32'h1);
    chk("nto_still_req", 32'(mem_req), 32'h1);
    chk("nto_no_wb", 32'(wb_valid), 32'h0);
    chk("nto_err_zero", 32'(mem_err), 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h4321;
    tick();
    mem_ack = 1'b0;
    chk("nto_late_ack", 32'(wb_data), 32'h4321);
    tick();
`endif

    // Randomized traffic against the reference model (DUT is idle here).
    m_busy = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ex_valid   = ($urandom_range(0, 1) == 1);
      sel        = int'($urandom_range(0, 3));
      ex_mem_rd  = (sel == 1) || (sel == 3);
      ex_mem_wr  = (sel == 2) || (sel == 3);
      ex_alu_out = DW'($urandom);
      ex_st_data = DW'($urandom);
      ex_dst     = 4'($urandom);
      ex_reg_wr  = ($urandom_range(0, 1) == 1);
      mem_ack    = ($urandom_range(0, 3) == 0);
      mem_rdata  = DW'($urandom);
      model_edge();
      tick();
      chk("rnd_stall", 32'(stall), 32'(m_busy));
      chk("rnd_mem_req", 32'(mem_req), 32'(m_busy));
      chk("rnd_wb_valid", 32'(wb_valid), 32'(e_wb_valid));
      chk("rnd_mem_err", 32'(mem_err), 32'(e_err));
      if (m_busy) begin
        chk("rnd_mem_we", 32'(mem_we), 32'(m_is_st));
        chk("rnd_mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("rnd_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      if (e_wb_valid) begin
        chk("rnd_wb_reg_wr", 32'(wb_reg_wr), 32'(e_wb_reg_wr));
        if (!e_err) begin
          chk("rnd_wb_data", 32'(wb_data), 32'(e_wb_data));
          chk("rnd_wb_dst", 32'(wb_dst), 32'(e_wb_dst));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
